// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;
    localparam int unsigned UART_DATA_BITS_DEFAULT  = 8;

    // PARITY is only reached when UART_RX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs (rx line, CTS).
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive engine: oversampled 8N1 deframer with holding register and error flags.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit (8E1).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS_DEFAULT,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sample_tick,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF_M = OVERSAMPLE / 2 - 1;
    localparam int unsigned FULL_M = OVERSAMPLE - 1;

    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n, ovr_n, perr_n;
    logic                 rxs;
    logic                 tick;
    logic                 at_half, at_full;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_bit_n;
`endif

    uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sin),
        .q   (rxs)
    );

    assign tick    = en & sample_tick;
    assign at_half = (cnt == CNT_W'(HALF_M));
    assign at_full = (cnt == CNT_W'(FULL_M));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            rx_data    <= data_n;
            rx_valid   <= valid_n;
            frame_err  <= ferr_n;
            overrun    <= ovr_n;
            parity_err <= perr_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
`endif
        end
    end

    // Next-state, deframing and holding-register logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        data_n    = rx_data;
        valid_n   = rx_valid;
        ferr_n    = frame_err;
        ovr_n     = overrun;
        perr_n    = parity_err;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
`endif

        if (rx_ack && rx_valid) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
            ferr_n  = 1'b0;
            perr_n  = 1'b0;
        end

        if (!en) begin
            state_n   = IDLE;
            cnt_n     = '0;
            bit_cnt_n = '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt_n   = '0;
                        state_n = START;
                    end
                end
                START: begin
                    if (at_half) begin
                        cnt_n = '0;
                        if (!rxs) begin
                            bit_cnt_n = '0;
                            state_n   = DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (at_full) begin
                        shift_n   = {rxs, shift[DATA_BITS-1:1]};
                        cnt_n     = '0;
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_full) begin
                        par_bit_n = rxs;
                        cnt_n     = '0;
                        state_n   = STOP;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (at_full) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                        // A same-cycle ack frees the holding register for this byte
                        if (!rx_valid || rx_ack) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                            ferr_n  = ~rxs;
                            ovr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
                            perr_n  = (^shift) ^ par_bit;
`else
                            perr_n  = 1'b0;
`endif
                        end else begin
                            ovr_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver; define UART_RX_PARITY_EN to exercise the 8E1 build.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // posedges from start-bit fall to the mid-stop sample when ticking every clk
    localparam int STOP_SAMPLE = 11 + OS * (8 + 1 + PAR_BITS);

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, sample_tick, sin, rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rise  = 0;
    int   div     = 1;
    int   phase   = 0;
    int   rise0;

    uart_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sample_tick (sample_tick),
        .sin         (sin),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic b);
        sin = b;
        repeat (OS * div) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input logic ferr, input logic pflip);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        e.perr = (PAR_BITS != 0) ? pflip : 1'b0;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        @(negedge clk);
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(d[i]);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ pflip);
`endif
        if (stop) begin
            hold(1'b1);
        end else begin
            // broken stop bit, released before the next start-bit check
            sin = 1'b0;
            repeat (12 * div) @(negedge clk);
            sin = 1'b1;
            repeat (4 * div) @(negedge clk);
        end
        sin = 1'b1;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Oversampling strobe, one every div clks
    initial begin
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            phase       = (phase + 1) % div;
            sample_tick = (phase == 0);
        end
    end

    // Scoreboard monitor: every new delivery pops and compares
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 && prev === 1'b0) begin
                n_rise++;
                check("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("frame_err", 32'(frame_err), 32'(e.ferr));
                    check("parity_err", 32'(parity_err), 32'(e.perr));
                end
            end
            prev = rx_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b1; en = 1'b1; sin = 1'b1; rx_ack = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);

        // 0xA5 with a tick every 4 clks
        div = 4;
        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_ovr", 32'(overrun), 32'd0);
        pulse_ack();
        check("a5_ack_valid", 32'(rx_valid), 32'd0);
        check("a5_ack_data", 32'(rx_data), 32'hA5);
        div = 1;
        repeat (8) @(negedge clk);

        // start-bit glitch is rejected, next frame is clean
        sin = 1'b0;
        repeat (4) @(negedge clk);
        sin = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("5a_valid", 32'(rx_valid), 32'd1);
        pulse_ack();

        // framing error still delivers the byte
        push(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (OS * 2) @(negedge clk);
        check("3c_valid", 32'(rx_valid), 32'd1);
        check("3c_ferr", 32'(frame_err), 32'd1);
        pulse_ack();
        check("3c_ack_ferr", 32'(frame_err), 32'd0);
        check("3c_ack_valid", 32'(rx_valid), 32'd0);

        // overrun: 0x22 dropped, then 0x33 accepted with a same-cycle ack
        push(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        fork
            send_frame(8'h33, 1'b1, 1'b0);
            begin
                @(negedge clk);
                repeat (STOP_SAMPLE - 1) @(posedge clk);
                @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        check("33_data", 32'(rx_data), 32'h33);
        check("33_ovr", 32'(overrun), 32'd0);
        check("33_valid", 32'(rx_valid), 32'd1);
        check("33_ferr", 32'(frame_err), 32'd0);
        pulse_ack();
        check("33_ack_valid", 32'(rx_valid), 32'd0);

        // abort a partial 0xFF frame with rst, then with en
        for (int k = 0; k < 2; k++) begin
            rise0 = n_rise;
            @(negedge clk);
            hold(1'b0);
            for (int i = 0; i < 4; i++) hold(1'b1);
            if (k == 0) rst = 1'b1; else en = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            en  = 1'b1;
            repeat (OS * 8) @(negedge clk);
            push(8'h81, 1'b0, 1'b0);
            send_frame(8'h81, 1'b1, 1'b0);
            repeat (2) @(negedge clk);
            check(k == 0 ? "rst_abort_rises" : "en_abort_rises", 32'(n_rise - rise0), 32'd1);
            check(k == 0 ? "rst_abort_data" : "en_abort_data", 32'(rx_data), 32'h81);
            pulse_ack();
        end

`ifdef UART_RX_PARITY_EN
        // even parity: correct bit, then flipped bit
        for (int k = 0; k < 2; k++) begin
            push(8'h07, 1'b0, k[0]);
            send_frame(8'h07, 1'b1, k[0]);
            repeat (2) @(negedge clk);
            check("par_valid", 32'(rx_valid), 32'd1);
            pulse_ack();
            check("par_ack_perr", 32'(parity_err), 32'd0);
        end
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("final_perr", 32'(parity_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive engine. Consumes the oversampling strobe produced by the UART clock generator (its rising_edge output, configured for OVERSAMPLE× baud).
- Deframes 8N1 frames (optionally 8E1) from the pad-side rx line.
- Presents each byte in a holding register with a valid/ack handshake to the UART register block, and flags framing and overrun errors.

Parameters:
- DATA_BITS, 8, data bits per frame, shifted in LSB first.
- OVERSAMPLE, 16, sample_tick strobes per bit period; must be an even number ≥ 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  receiver enable.
- sample_tick  input  1  one-clk strobe at OVERSAMPLE× baud.
- sin  input  1  asynchronous serial input; idles high.
- rx_data  output  DATA_BITS  holding register.
- rx_valid  output  1  holding register full.
- rx_ack  input  1  consumer pulse; empties the holding register.
- frame_err  output  1  stop bit sampled low for the held byte.
- overrun  output  1  a frame was lost while rx_valid was high.
- parity_err  output  1  parity mismatch for the held byte (see Optional Feature).

Behaviour:
- Reset state: FSM in IDLE; tick counter and bit counter at 0; shift register 0; rx_data 0; rx_valid 0; frame_err 0; overrun 0; parity_err 0; synchronizer flops 1.
- Input synchronizer: sin passes through a 2-flop synchronizer. All sampling below uses the synchronized value, rxs.
- Counter gating: the tick counter (width $clog2(OVERSAMPLE)) advances only on cycles with en=1 and sample_tick=1.
- IDLE:
  - On a tick with rxs=0: tick counter := 0, go to START.
- START:
  - At tick count OVERSAMPLE/2-1 (mid start bit), if rxs=0: counter := 0, bit counter := 0, go to DATA.
  - At the same point, if rxs=1: false start; return to IDLE with no flag set.
- DATA:
  - At tick count OVERSAMPLE-1: shift rxs into the MSB of the shift register (right shift, so the byte ends up LSB-first-correct), counter := 0, increment the bit counter.
  - After the bit with index DATA_BITS-1: go to STOP, or to PARITY if the feature is compiled in.
- STOP:
  - At tick count OVERSAMPLE-1 (mid stop bit): complete the frame and go directly to IDLE. This allows back-to-back frames.
- Frame completion, same edge as the stop sample; outputs visible the following cycle:
  - If rx_valid=0, or rx_ack=1 in that same cycle: rx_data := shift register; rx_valid := 1; frame_err := ~rxs; parity_err := computed value; overrun := 0.
  - Otherwise the new byte is discarded; rx_data, frame_err and parity_err are unchanged; overrun := 1.
  - A byte with a framing error is still delivered.
- rx_ack:
  - While rx_valid=1: clears rx_valid, overrun, frame_err and parity_err on the next edge. rx_data is retained.
  - While rx_valid=0: no effect.
- en=0: FSM forced to IDLE and counters cleared at the next edge, abandoning any partial frame. The holding register, flags and the ack path stay operational.
- rst mid-frame: all state returns to reset values at the next edge; a partial frame is never delivered.
- Latency: rx_valid rises 1 clk after the tick that samples mid-stop-bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - Samples one bit at mid-bit.
  - parity_err := (XOR of data bits) XOR (sampled bit), i.e. even parity.
- Undefined:
  - No PARITY state; the frame is 8N1.
  - parity_err is constant 0.
  - The port exists in both builds.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP} (PARITY is unused when the macro is undefined);
  - the UART_OVERSAMPLE_DEFAULT=16 constant;
  - the UART_DATA_BITS_DEFAULT=8 constant.
- Sub-module: uart_sync_2ff, a generic 2-flop synchronizer with a reset value parameter. The transmit-side CTS input will reuse it.

Test Plan (sample_tick=1 every clk unless noted, OVERSAMPLE=16):
- Frame 0xA5, 8N1, sample_tick every 4 clks -> rx_data=0xA5, rx_valid=1, frame_err=0, overrun=0; after rx_ack pulse, rx_valid=0 and rx_data still 0xA5.
- sin low for 4 ticks then high (glitch) -> FSM back to IDLE, rx_valid stays 0. A valid 0x5A frame that follows -> rx_data=0x5A.
- Frame 0x3C with stop bit driven 0 -> rx_data=0x3C, rx_valid=1, frame_err=1. rx_ack -> frame_err=0.
- Back-to-back frames 0x11 and 0x22 with no ack -> rx_data=0x11, overrun=1. A third frame 0x33 sent with rx_ack asserted on its completion cycle -> rx_data=0x33, overrun=0.
- rst=1 for 1 clk after 4 data bits of 0xFF, then a full 0x81 frame -> only 0x81 delivered, exactly one rx_valid rise. Repeat the abort using en=0; the result is the same.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1. Without the macro, parity_err=0 throughout all of the above.
